// File: rtl/lcm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lcm_pkg
//  Brief    : Shared FAST-stream encodings and dispatcher FSM types.
//  Revision : 1.0  initial release
// ============================================================================
package lcm_pkg;

    localparam int DATA_W = 134;

    localparam logic [1:0] FR_HEAD = 2'b01;
    localparam logic [1:0] FR_BODY = 2'b11;
    localparam logic [1:0] FR_TAIL = 2'b10;

    localparam logic [2:0] BEACON_TYPE_DEF = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TO_LCM = 3'd1,
        ST_TO_BYP = 3'd2,
        ST_DROP   = 3'd3,
        ST_WAIT_V = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_LCM  = 2'd1,
        DST_BYP  = 2'd2
    } dest_t;

    function automatic logic [1:0] frame_of(input logic [DATA_W-1:0] word);
        return word[DATA_W-1:DATA_W-2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcm_dispatch_out.sv
`default_nettype none
// ============================================================================
//  Module   : lcm_dispatch_out
//  Brief    : Registered output slice for one FAST stream (data/wr/valid).
//  Revision : 1.0  initial release
// ============================================================================
module lcm_dispatch_out
    import lcm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              wr,
    input  logic              valid,
    input  logic              valid_wr,
    input  logic              force_invalid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wr,
    output logic              out_valid,
    output logic              out_valid_wr
);

    // Data holds its last written word; valid is only meaningful with valid_wr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data     <= '0;
            out_wr       <= 1'b0;
            out_valid    <= 1'b0;
            out_valid_wr <= 1'b0;
        end else begin
            out_wr       <= wr;
            out_valid_wr <= valid_wr;
            out_valid    <= valid_wr & valid & ~force_invalid;
            if (wr) begin
                out_data <= data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcm_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : lcm_dispatch
//  Brief    : Splits the ingress FAST stream into beacon (lcm) and bypass
//             outputs at packet granularity. Define LCM_DISPATCH_CNT_EN to
//             add per-destination packet counters.
//  Revision : 1.0  initial release
// ============================================================================
module lcm_dispatch
    import lcm_pkg::*;
#(
    parameter int         TYPE_LSB    = 120,
    parameter logic [2:0] BEACON_TYPE = BEACON_TYPE_DEF,
    parameter int         MAX_WORDS   = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_data_wr,
    input  logic              in_data_valid,
    input  logic              in_data_valid_wr,
    input  logic              lcm_ready,
    input  logic              byp_ready,
    output logic [DATA_W-1:0] out_lcm_data,
    output logic              out_lcm_data_wr,
    output logic              out_lcm_data_valid,
    output logic              out_lcm_data_valid_wr,
    output logic [DATA_W-1:0] out_byp_data,
    output logic              out_byp_data_wr,
    output logic              out_byp_data_valid,
    output logic              out_byp_data_valid_wr,
`ifdef LCM_DISPATCH_CNT_EN
    output logic [31:0]       lcm_pkt_cnt,
    output logic [31:0]       byp_pkt_cnt,
    output logic [31:0]       drop_pkt_cnt,
`endif
    output logic [15:0]       err_cnt
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    state_t           r_state, w_nxt_state;
    dest_t            r_dest, w_nxt_dest, w_new_dest;
    logic [CNT_W-1:0] r_wcnt, w_nxt_wcnt;
    logic             r_ovl, w_nxt_ovl;

    logic w_head, w_bt, w_tail, w_in_room;
    logic w_dispatch, w_abort, w_fwd_word, w_close, w_ovl_now, w_err, w_force;
    logic w_lcm_wr, w_lcm_vwr, w_lcm_valid;
    logic w_byp_wr, w_byp_vwr, w_byp_valid;

    assign w_head    = in_data_wr && (frame_of(in_data) == FR_HEAD);
    assign w_tail    = in_data_wr && (frame_of(in_data) == FR_TAIL);
    assign w_bt      = in_data_wr && ((frame_of(in_data) == FR_BODY) || w_tail);
    assign w_in_room = r_wcnt < CNT_W'(MAX_WORDS);

    // Readies are looked at only here, i.e. only on a head word.
    always_comb begin
        w_new_dest = DST_NONE;
        if (in_data[TYPE_LSB+2:TYPE_LSB] == BEACON_TYPE) begin
            if (lcm_ready) w_new_dest = DST_LCM;
        end else if (byp_ready) begin
            w_new_dest = DST_BYP;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_dest  = r_dest;
        w_nxt_wcnt  = r_wcnt;
        w_nxt_ovl   = r_ovl;
        w_dispatch  = 1'b0;
        w_abort     = 1'b0;
        w_fwd_word  = 1'b0;
        w_close     = 1'b0;
        w_ovl_now   = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_head)    w_dispatch = 1'b1;
                else if (w_bt) w_err      = 1'b1;
            end
            ST_TO_LCM, ST_TO_BYP, ST_DROP: begin
                if (w_head) begin
                    w_abort    = 1'b1;
                    w_err      = 1'b1;
                    w_dispatch = 1'b1;
                end else if (w_bt) begin
                    if (w_in_room) begin
                        w_fwd_word = 1'b1;
                        w_nxt_wcnt = r_wcnt + 1'b1;
                    end else begin
                        w_ovl_now = 1'b1;
                        w_nxt_ovl = 1'b1;
                        w_err     = ~r_ovl;
                    end
                    if (w_tail) begin
                        if (in_data_valid_wr) begin
                            w_close     = 1'b1;
                            w_nxt_state = ST_IDLE;
                        end else begin
                            w_nxt_state = ST_WAIT_V;
                        end
                    end
                end
            end
            ST_WAIT_V: begin
                if (in_data_valid_wr) begin
                    w_close     = 1'b1;
                    w_nxt_state = ST_IDLE;
                end
                // A head with no closing strobe abandons the previous packet.
                if (w_head) begin
                    w_dispatch = 1'b1;
                    w_abort    = ~in_data_valid_wr;
                    w_err      = ~in_data_valid_wr;
                end else if (w_bt) begin
                    w_err = 1'b1;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase

        if (w_dispatch) begin
            w_nxt_dest = w_new_dest;
            w_nxt_wcnt = CNT_W'(1);
            w_nxt_ovl  = 1'b0;
            case (w_new_dest)
                DST_LCM: w_nxt_state = ST_TO_LCM;
                DST_BYP: w_nxt_state = ST_TO_BYP;
                default: w_nxt_state = ST_DROP;
            endcase
        end
    end

    assign w_force = r_ovl | w_ovl_now;

    assign w_lcm_wr    = (w_fwd_word && r_dest == DST_LCM) || (w_dispatch && w_new_dest == DST_LCM);
    assign w_lcm_vwr   = (w_close || w_abort) && r_dest == DST_LCM;
    assign w_lcm_valid = w_close && in_data_valid;
    assign w_byp_wr    = (w_fwd_word && r_dest == DST_BYP) || (w_dispatch && w_new_dest == DST_BYP);
    assign w_byp_vwr   = (w_close || w_abort) && r_dest == DST_BYP;
    assign w_byp_valid = w_close && in_data_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dest  <= DST_NONE;
            r_wcnt  <= '0;
            r_ovl   <= 1'b0;
            err_cnt <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_dest  <= w_nxt_dest;
            r_wcnt  <= w_nxt_wcnt;
            r_ovl   <= w_nxt_ovl;
            if (w_err && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

`ifdef LCM_DISPATCH_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcm_pkt_cnt  <= '0;
            byp_pkt_cnt  <= '0;
            drop_pkt_cnt <= '0;
        end else begin
            if (w_lcm_vwr && w_lcm_valid && !w_force) lcm_pkt_cnt <= lcm_pkt_cnt + 32'd1;
            if (w_byp_vwr && w_byp_valid && !w_force) byp_pkt_cnt <= byp_pkt_cnt + 32'd1;
            if (w_dispatch && w_new_dest == DST_NONE) drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
        end
    end
`endif

    lcm_dispatch_out u_out_lcm (
        .clk           (clk),
        .rst_n         (rst_n),
        .data          (in_data),
        .wr            (w_lcm_wr),
        .valid         (w_lcm_valid),
        .valid_wr      (w_lcm_vwr),
        .force_invalid (w_force),
        .out_data      (out_lcm_data),
        .out_wr        (out_lcm_data_wr),
        .out_valid     (out_lcm_data_valid),
        .out_valid_wr  (out_lcm_data_valid_wr)
    );

    lcm_dispatch_out u_out_byp (
        .clk           (clk),
        .rst_n         (rst_n),
        .data          (in_data),
        .wr            (w_byp_wr),
        .valid         (w_byp_valid),
        .valid_wr      (w_byp_vwr),
        .force_invalid (w_force),
        .out_data      (out_byp_data),
        .out_wr        (out_byp_data_wr),
        .out_valid     (out_byp_data_valid),
        .out_valid_wr  (out_byp_data_valid_wr)
    );

endmodule
`default_nettype wire
